// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered EX-stage ALU with ALUOp/Funct decode and
// multi-cycle unsigned MULTU/DIVU into HI/LO, read back via MFHI/MFLO.
// Ports:
//   clk, reset (async, active-high)
//   start, alu_op[2:0], funct[5:0], a, b   : operation launch
//   result, zero, illegal, div_zero        : registered, valid with done
//   busy, done                             : multi-cycle handshake
//   hi, lo                                 : HI/LO registers

module alu_seq_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIN
   } state_t;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_NOP   = 6'b000000;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   // MUL/DIV run WIDTH-1 steps; the final step is folded into FIN,
   // which commits it, so start->done is WIDTH+1 cycles.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 2);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div;

   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_done;
   logic               r_illegal;
   logic               r_div_zero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_divisor;

   logic [WIDTH-1:0]   w_res;
   logic               w_ill;
   logic               w_is_mul;
   logic               w_is_div;
   logic               w_slt;
   logic               w_sltu;
   logic               w_gtz;
   logic               w_b_nz;

   logic [2*WIDTH-1:0] w_acc_nx;
   logic [WIDTH:0]     w_rem_sh;
   logic               w_ge;
   logic [WIDTH-1:0]   w_rem_nx;
   logic [WIDTH-1:0]   w_quot_nx;

   assign w_slt  = $signed(a) < $signed(b);
   assign w_sltu = a < b;
   assign w_gtz  = ~a[WIDTH-1] & (|a);
   assign w_b_nz = |b;

   always_comb begin
      w_res    = '0;
      w_ill    = 1'b0;
      w_is_mul = 1'b0;
      w_is_div = 1'b0;
      case (alu_op)
         3'b000: w_res = a + b;
         3'b001: w_res = a - b;
         3'b100: w_res = a & b;
         3'b101: w_res = a | b;
         3'b111: w_res = {{(WIDTH-1){1'b0}}, w_slt};
         3'b110: w_res = {{(WIDTH-1){1'b0}}, w_gtz};
         3'b010: begin
            case (funct)
               F_ADD:   w_res = a + b;
               F_SUB:   w_res = a - b;
               F_AND:   w_res = a & b;
               F_OR:    w_res = a | b;
               F_XOR:   w_res = a ^ b;
               F_NOR:   w_res = ~(a | b);
               F_SLT:   w_res = {{(WIDTH-1){1'b0}}, w_slt};
               F_SLTU:  w_res = {{(WIDTH-1){1'b0}}, w_sltu};
               F_NOP:   w_res = '0;
               F_MFHI:  w_res = r_hi;
               F_MFLO:  w_res = r_lo;
               F_MULTU: w_is_mul = 1'b1;
               F_DIVU:  w_is_div = 1'b1;
               default: w_ill = 1'b1;
            endcase
         end
         // 3'b011 is NOP
         default: w_res = '0;
      endcase
   end

   // one shift-add step
   assign w_acc_nx = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   // one restoring-division step; the difference always fits WIDTH
   // bits because the partial remainder stays below the divisor
   assign w_rem_sh  = {r_rem, r_quot[WIDTH-1]};
   assign w_ge      = w_rem_sh >= {1'b0, r_divisor};
   assign w_rem_nx  = w_ge ? (w_rem_sh[WIDTH-1:0] - r_divisor)
                           : w_rem_sh[WIDTH-1:0];
   assign w_quot_nx = {r_quot[WIDTH-2:0], w_ge};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start && w_is_mul)
               w_next = S_MUL;
            else if (start && w_is_div && w_b_nz)
               w_next = S_DIV;
         end
         S_MUL, S_DIV: begin
            if (r_cnt == LAST_CNT) w_next = S_FIN;
         end
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_is_div   <= 1'b0;
         r_result   <= '0;
         r_zero     <= 1'b1;
         r_done     <= 1'b0;
         r_illegal  <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_rem      <= '0;
         r_quot     <= '0;
         r_divisor  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_is_mul) begin
                     r_acc    <= '0;
                     r_mcand  <= {{WIDTH{1'b0}}, a};
                     r_mplier <= b;
                     r_cnt    <= '0;
                     r_is_div <= 1'b0;
                  end else if (w_is_div && w_b_nz) begin
                     r_rem     <= '0;
                     r_quot    <= a;
                     r_divisor <= b;
                     r_cnt     <= '0;
                     r_is_div  <= 1'b1;
                  end else if (w_is_div) begin
                     r_result   <= '1;
                     r_zero     <= 1'b0;
                     r_lo       <= '1;
                     r_hi       <= a;
                     r_illegal  <= 1'b0;
                     r_div_zero <= 1'b1;
                     r_done     <= 1'b1;
                  end else begin
                     r_result   <= w_res;
                     r_zero     <= (w_res == '0);
                     r_illegal  <= w_ill;
                     r_div_zero <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_nx;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
            end
            S_DIV: begin
               r_rem  <= w_rem_nx;
               r_quot <= w_quot_nx;
               r_cnt  <= r_cnt + CNT_W'(1);
            end
            S_FIN: begin
               if (r_is_div) begin
                  r_lo     <= w_quot_nx;
                  r_hi     <= w_rem_nx;
                  r_result <= w_quot_nx;
                  r_zero   <= (w_quot_nx == '0);
               end else begin
                  {r_hi, r_lo} <= w_acc_nx;
                  r_result     <= w_acc_nx[WIDTH-1:0];
                  r_zero       <= (w_acc_nx[WIDTH-1:0] == '0);
               end
               r_illegal  <= 1'b0;
               r_div_zero <= 1'b0;
               r_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result   = r_result;
   assign zero     = r_zero;
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign illegal  = r_illegal;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: self-checking bench for alu_seq_unit at WIDTH=32
// and WIDTH=8, directed scenarios plus randomized back-to-back ops.

module tb_alu_seq_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst32 = 1'b1;
   logic        st32 = 1'b0;
   logic [2:0]  op32 = '0;
   logic [5:0]  fn32 = '0;
   logic [31:0] a32 = '0;
   logic [31:0] b32 = '0;
   logic [31:0] res32, hi32, lo32;
   logic        z32, busy32, done32, ill32, dz32;

   logic        rst8 = 1'b1;
   logic        st8 = 1'b0;
   logic [2:0]  op8 = '0;
   logic [5:0]  fn8 = '0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic [7:0]  res8, hi8, lo8;
   logic        z8, busy8, done8, ill8, dz8;

   int n_tests = 0;
   int n_fail = 0;

   logic [63:0] m_hi32 = '0, m_lo32 = '0;
   logic [63:0] m_hi8 = '0, m_lo8 = '0;

   alu_seq_unit #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(rst32), .start(st32),
      .alu_op(op32), .funct(fn32), .a(a32), .b(b32),
      .result(res32), .zero(z32), .busy(busy32), .done(done32),
      .illegal(ill32), .div_zero(dz32), .hi(hi32), .lo(lo32)
   );

   alu_seq_unit #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(rst8), .start(st8),
      .alu_op(op8), .funct(fn8), .a(a8), .b(b8),
      .result(res8), .zero(z8), .busy(busy8), .done(done8),
      .illegal(ill8), .div_zero(dz8), .hi(hi8), .lo(lo8)
   );

   // Reference model: plain arithmetic on the operation's meaning.
   task automatic model(
      input  int          w,
      input  logic [2:0]  op,
      input  logic [5:0]  f,
      input  logic [63:0] a,
      input  logic [63:0] b,
      inout  logic [63:0] hi,
      inout  logic [63:0] lo,
      output logic [63:0] res,
      output logic        ill,
      output logic        dz,
      output int          lat
   );
      logic [63:0] mask, p;
      longint sa, sb;
      mask = (64'd1 << w) - 64'd1;
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - longint'(64'd1 << w);
      if (b[w-1]) sb = sb - longint'(64'd1 << w);
      res = '0; ill = 1'b0; dz = 1'b0; lat = 1;
      case (op)
         3'd0: res = (a + b) & mask;
         3'd1: res = (a - b) & mask;
         3'd4: res = a & b;
         3'd5: res = a | b;
         3'd7: res = (sa < sb) ? 64'd1 : 64'd0;
         3'd6: res = (sa > 0) ? 64'd1 : 64'd0;
         3'd3: res = '0;
         default: begin
            case (f)
               6'h20: res = (a + b) & mask;
               6'h22: res = (a - b) & mask;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h26: res = a ^ b;
               6'h27: res = ~(a | b) & mask;
               6'h2a: res = (sa < sb) ? 64'd1 : 64'd0;
               6'h2b: res = (a < b) ? 64'd1 : 64'd0;
               6'h00: res = '0;
               6'h10: res = hi;
               6'h12: res = lo;
               6'h19: begin
                  p = a * b;
                  hi = (p >> w) & mask;
                  lo = p & mask;
                  res = lo;
                  lat = w + 1;
               end
               6'h1b: begin
                  if (b == 0) begin
                     res = mask; lo = mask; hi = a; dz = 1'b1;
                  end else begin
                     res = a / b; lo = a / b; hi = a % b;
                     lat = w + 1;
                  end
               end
               default: ill = 1'b1;
            endcase
         end
      endcase
   endtask

   // Drives one start at the current negedge, scrambles the inputs
   // afterwards, and returns at the negedge where done is seen.
   task automatic run32(
      input  logic [2:0]  op,
      input  logic [5:0]  f,
      input  logic [31:0] a,
      input  logic [31:0] b,
      output int          lat,
      output int          bn
   );
      st32 = 1'b1; op32 = op; fn32 = f; a32 = a; b32 = b;
      lat = 0; bn = 0;
      while (1) begin
         @(negedge clk);
         st32 = 1'b0;
         a32 = $urandom; b32 = $urandom;
         op32 = 3'($urandom); fn32 = 6'($urandom);
         lat++;
         if (busy32) bn++;
         if (done32 || lat >= 200) break;
      end
      if (!done32) lat = -1;
   endtask

   task automatic run8(
      input  logic [2:0] op,
      input  logic [5:0] f,
      input  logic [7:0] a,
      input  logic [7:0] b,
      output int         lat,
      output int         bn
   );
      st8 = 1'b1; op8 = op; fn8 = f; a8 = a; b8 = b;
      lat = 0; bn = 0;
      while (1) begin
         @(negedge clk);
         st8 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom);
         lat++;
         if (busy8) bn++;
         if (done8 || lat >= 100) break;
      end
      if (!done8) lat = -1;
   endtask

   task automatic pick(output logic [2:0] op, output logic [5:0] f);
      logic [5:0] tbl [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
         6'h27, 6'h2a, 6'h2b, 6'h00, 6'h10, 6'h12, 6'h19};
      op = 3'($urandom);
      if (op == 3'd2 && $urandom_range(0, 3) == 0) op = 3'd2;
      case ($urandom_range(0, 9))
         0:       f = 6'($urandom);
         1, 2:    f = 6'h1b;
         default: f = tbl[$urandom_range(0, 11)];
      endcase
   endtask

   task automatic test_reset();
      rst32 = 1'b1; rst8 = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({res32, z32, busy32, done32, ill32, dz32, hi32, lo32} !==
          {32'd0, 1'b1, 4'd0, 64'd0}) begin
         n_fail++;
         $display("FAIL reset32: res=%h z=%b b=%b d=%b hi=%h lo=%h",
                  res32, z32, busy32, done32, hi32, lo32);
      end
      n_tests++;
      if ({res8, z8, busy8, done8, ill8, dz8, hi8, lo8} !==
          {8'd0, 1'b1, 4'd0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset8: res=%h z=%b hi=%h lo=%h exp 0/1/0/0",
                  res8, z8, hi8, lo8);
      end
      rst32 = 1'b0; rst8 = 1'b0;
      m_hi32 = '0; m_lo32 = '0; m_hi8 = '0; m_lo8 = '0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int lat, bn;
      run32(3'b010, 6'h20, 32'd5, 32'd7, lat, bn);
      n_tests++;
      if ({res32, z32, 32'(lat), 32'(bn)} !== {32'd12, 1'b0, 32'd1, 32'd0})
      begin
         n_fail++;
         $display("FAIL add: res=%0d z=%b lat=%0d busy=%0d exp 12/0/1/0",
                  res32, z32, lat, bn);
      end
      @(negedge clk);
      n_tests++;
      if (done32 !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: done=%b exp 0", done32);
      end
      run32(3'b010, 6'h2a, 32'hFFFFFFFF, 32'd1, lat, bn);
      n_tests++;
      if (res32 !== 32'd1) begin
         n_fail++;
         $display("FAIL slt: res=%h exp 1", res32);
      end
      run32(3'b010, 6'h2b, 32'hFFFFFFFF, 32'd1, lat, bn);
      n_tests++;
      if ({res32, z32} !== {32'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL sltu: res=%h z=%b exp 0/1", res32, z32);
      end
      run32(3'b110, 6'h00, 32'd0, 32'd9, lat, bn);
      n_tests++;
      if ({res32, z32} !== {32'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL bgtz0: res=%h z=%b exp 0/1", res32, z32);
      end
      run32(3'b110, 6'h00, 32'd3, 32'd0, lat, bn);
      n_tests++;
      if (res32 !== 32'd1) begin
         n_fail++;
         $display("FAIL bgtz3: res=%h exp 1", res32);
      end
   endtask

   task automatic test_multu();
      int lat, bn;
      run32(3'b010, 6'h19, 32'hFFFFFFFF, 32'd2, lat, bn);
      m_hi32 = 64'd1; m_lo32 = 64'hFFFFFFFE;
      n_tests++;
      if ({hi32, lo32, res32, 32'(lat), 32'(bn)} !==
          {32'd1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd33, 32'd32}) begin
         n_fail++;
         $display("FAIL multu: hi=%h lo=%h res=%h lat=%0d busy=%0d",
                  hi32, lo32, res32, lat, bn);
      end
      run32(3'b010, 6'h10, 32'd0, 32'd0, lat, bn);
      n_tests++;
      if (res32 !== 32'd1) begin
         n_fail++;
         $display("FAIL mfhi: res=%h exp 1", res32);
      end
      run32(3'b010, 6'h12, 32'd0, 32'd0, lat, bn);
      n_tests++;
      if (res32 !== 32'hFFFFFFFE) begin
         n_fail++;
         $display("FAIL mflo: res=%h exp fffffffe", res32);
      end
   endtask

   task automatic test_divu();
      int lat, bn;
      run32(3'b010, 6'h1b, 32'd100, 32'd7, lat, bn);
      n_tests++;
      if ({lo32, hi32, res32, dz32, 32'(lat)} !==
          {32'd14, 32'd2, 32'd14, 1'b0, 32'd33}) begin
         n_fail++;
         $display("FAIL divu: lo=%0d hi=%0d res=%0d dz=%b lat=%0d",
                  lo32, hi32, res32, dz32, lat);
      end
      run32(3'b010, 6'h1b, 32'd9, 32'd0, lat, bn);
      m_hi32 = 64'd9; m_lo32 = 64'hFFFFFFFF;
      n_tests++;
      if ({lo32, hi32, res32, dz32, z32, 32'(lat), 32'(bn)} !==
          {32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd1, 32'd0})
      begin
         n_fail++;
         $display("FAIL divu0: lo=%h hi=%h dz=%b lat=%0d busy=%0d",
                  lo32, hi32, dz32, lat, bn);
      end
      run32(3'b000, 6'h00, 32'd1, 32'd1, lat, bn);
      n_tests++;
      if ({dz32, res32} !== {1'b0, 32'd2}) begin
         n_fail++;
         $display("FAIL dz_clear: dz=%b res=%h exp 0/2", dz32, res32);
      end
   endtask

   task automatic test_ignore_start();
      int dones = 0, first = -1;
      logic [31:0] r_at = '0;
      st32 = 1'b1; op32 = 3'b010; fn32 = 6'h19;
      a32 = 32'd12345; b32 = 32'd678;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         st32 = (c == 5 || c == 32);
         op32 = 3'b000; a32 = 32'd1; b32 = 32'd1;
         if (done32) begin
            dones++;
            if (first < 0) begin first = c; r_at = res32; end
         end
      end
      m_hi32 = '0; m_lo32 = 64'(32'd12345 * 32'd678);
      n_tests++;
      if ({32'(dones), 32'(first), r_at} !==
          {32'd1, 32'd33, m_lo32[31:0]}) begin
         n_fail++;
         $display("FAIL ignore_start: dones=%0d at=%0d res=%h exp 1/33/%h",
                  dones, first, r_at, m_lo32[31:0]);
      end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      st32 = 1'b1; op32 = 3'b010; fn32 = 6'h1b;
      a32 = 32'd1000; b32 = 32'd3;
      @(negedge clk);
      st32 = 1'b0;
      repeat (10) @(negedge clk);
      rst32 = 1'b1;
      #1;
      n_tests++;
      if ({res32, z32, busy32, done32, ill32, dz32, hi32, lo32} !==
          {32'd0, 1'b1, 4'd0, 64'd0}) begin
         n_fail++;
         $display("FAIL reset_mid: res=%h z=%b b=%b hi=%h lo=%h",
                  res32, z32, busy32, hi32, lo32);
      end
      @(negedge clk);
      rst32 = 1'b0;
      m_hi32 = '0; m_lo32 = '0;
      repeat (40) begin
         @(negedge clk);
         if (done32) dones++;
      end
      n_tests++;
      if ({32'(dones), hi32, lo32} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_mid_done: dones=%0d hi=%h lo=%h exp 0",
                  dones, hi32, lo32);
      end
   endtask

   task automatic test_illegal();
      int lat, bn;
      run32(3'b010, 6'h3f, 32'd5, 32'd6, lat, bn);
      n_tests++;
      if ({ill32, res32, z32, 32'(lat)} !== {1'b1, 32'd0, 1'b1, 32'd1})
      begin
         n_fail++;
         $display("FAIL illegal: ill=%b res=%h lat=%0d exp 1/0/1",
                  ill32, res32, lat);
      end
      run32(3'b000, 6'h3f, 32'd3, 32'd4, lat, bn);
      n_tests++;
      if ({ill32, res32} !== {1'b0, 32'd7}) begin
         n_fail++;
         $display("FAIL ill_clear: ill=%b res=%h exp 0/7", ill32, res32);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bn, elat;
      logic [2:0] op;
      logic [5:0] f;
      logic [31:0] a, b;
      logic [63:0] er;
      logic eil, edz;
      for (int i = 0; i < 40; i++) begin
         pick(op, f);
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         if (op == 3'd2 && f == 6'h1b && $urandom_range(0, 3) == 0)
            b = '0;
         model(32, op, f, {32'd0, a}, {32'd0, b}, m_hi32, m_lo32,
               er, eil, edz, elat);
         run32(op, f, a, b, lat, bn);
         n_tests++;
         if ({res32, z32, ill32, dz32, hi32, lo32, 32'(lat),
              32'(bn)} !==
             {er[31:0], er[31:0] == 0, eil, edz, m_hi32[31:0],
              m_lo32[31:0], 32'(elat), 32'(elat - 1)}) begin
            n_fail++;
            $display("FAIL rand32[%0d] op=%0d f=%h a=%h b=%h: res=%h il=%b dz=%b hi=%h lo=%h lat=%0d, exp res=%h il=%b dz=%b hi=%h lo=%h lat=%0d",
                     i, op, f, a, b, res32, ill32, dz32, hi32, lo32, lat,
                     er[31:0], eil, edz, m_hi32[31:0], m_lo32[31:0], elat);
         end
      end
   endtask

   task automatic test_w8();
      int lat, bn, elat;
      logic [2:0] op;
      logic [5:0] f;
      logic [7:0] a, b;
      logic [63:0] er;
      logic eil, edz;
      run8(3'b010, 6'h20, 8'd5, 8'd7, lat, bn);
      n_tests++;
      if ({res8, z8, 32'(lat), 32'(bn)} !== {8'd12, 1'b0, 32'd1, 32'd0})
      begin
         n_fail++;
         $display("FAIL add8: res=%0d lat=%0d busy=%0d exp 12/1/0",
                  res8, lat, bn);
      end
      run8(3'b010, 6'h19, 8'hFF, 8'hFF, lat, bn);
      m_hi8 = 64'hFE; m_lo8 = 64'h01;
      n_tests++;
      if ({hi8, lo8, res8, 32'(lat), 32'(bn)} !==
          {8'hFE, 8'h01, 8'h01, 32'd9, 32'd8}) begin
         n_fail++;
         $display("FAIL multu8: hi=%h lo=%h lat=%0d busy=%0d exp fe/01/9/8",
                  hi8, lo8, lat, bn);
      end
      for (int i = 0; i < 30; i++) begin
         pick(op, f);
         a = 8'($urandom); b = 8'($urandom);
         if (op == 3'd2 && f == 6'h1b && $urandom_range(0, 3) == 0)
            b = '0;
         model(8, op, f, {56'd0, a}, {56'd0, b}, m_hi8, m_lo8,
               er, eil, edz, elat);
         run8(op, f, a, b, lat, bn);
         n_tests++;
         if ({res8, z8, ill8, dz8, hi8, lo8, 32'(lat)} !==
             {er[7:0], er[7:0] == 0, eil, edz, m_hi8[7:0], m_lo8[7:0],
              32'(elat)}) begin
            n_fail++;
            $display("FAIL rand8[%0d] op=%0d f=%h a=%h b=%h: res=%h hi=%h lo=%h lat=%0d, exp res=%h hi=%h lo=%h lat=%0d",
                     i, op, f, a, b, res8, hi8, lo8, lat,
                     er[7:0], m_hi8[7:0], m_lo8[7:0], elat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multu();
      test_divu();
      test_ignore_start();
      test_reset_mid();
      test_illegal();
      test_back_to_back();
      test_w8();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
